// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: run control, redirect, instruction-memory load port,
// and the PC/instr/valid pair that feeds the IF/ID buffer.
//   slave  : the fetch stage (takes control and load inputs, drives PC/instr/valid)
//   master : the controller/downstream side
interface if_fetch_stage_if #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 32
);
  logic               start;
  logic               stall;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic               imem_we;
  logic [PC_W-1:0]    imem_waddr;
  logic [INSTR_W-1:0] imem_wdata;
  logic [PC_W-1:0]    PC;
  logic [INSTR_W-1:0] instr;
  logic               valid;

  modport slave (
    input  start, stall, branch_taken, branch_target,
    input  imem_we, imem_waddr, imem_wdata,
    output PC, instr, valid
  );

  modport master (
    output start, stall, branch_taken, branch_target,
    output imem_we, imem_waddr, imem_wdata,
    input  PC, instr, valid
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: registered PC, 2**PC_W x INSTR_W instruction memory
// (synchronous write, asynchronous read), and IDLE/RUN/HALT run control.
// Ports:
//   clk   : clock, all state updates on posedge
//   rst_n : synchronous active-low reset (PC and FSM only, not memory)
//   bus   : if_fetch_stage_if.slave (start/stall/branch in, load port in,
//           PC/instr/valid out)
module if_fetch_stage #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 32,
  parameter logic [3:0]  HALT_OP = 4'b1111
) (
  input  logic               clk,
  input  logic               rst_n,
  if_fetch_stage_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] mem [2**PC_W];
  logic               is_halt;

  // Memory is deliberately outside reset so preloaded programs survive it.
  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      mem[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign is_halt = (bus.instr[INSTR_W-1 -: 4] == HALT_OP);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          pc_d    = '0;
        end
      end
      StRun: begin
        // Branch wins over stall and over a wrong-path halt opcode.
        if (bus.branch_taken) begin
          pc_d = bus.branch_target;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (is_halt) begin
          state_d = StHalt;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.PC    = pc_q;
  assign bus.instr = mem[pc_q];
  assign bus.valid = (state_q == StRun);

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  if_fetch_stage_if #(.PC_W(8), .INSTR_W(32)) bus ();

  if_fetch_stage #(.PC_W(8), .INSTR_W(32), .HALT_OP(4'b1111)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_run(input string tag, input logic [7:0] pc, input logic [31:0] ins,
                         input logic vld);
    check({tag, ".pc"}, 32'(bus.PC), 32'(pc));
    check({tag, ".instr"}, bus.instr, ins);
    check({tag, ".valid"}, 32'(bus.valid), 32'(vld));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_branch(input logic [7:0] tgt, input logic stl);
    bus.branch_taken  = 1'b1;
    bus.branch_target = tgt;
    bus.stall         = stl;
    step();
    bus.branch_taken  = 1'b0;
    bus.stall         = 1'b0;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.start         = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.imem_we       = 1'b0;
    bus.imem_waddr    = '0;
    bus.imem_wdata    = '0;

    // Preload mem[i] = 0x1000 + i everywhere (writes work during reset).
    for (int i = 0; i < 256; i++) begin
      bus.imem_we    = 1'b1;
      bus.imem_waddr = 8'(i);
      bus.imem_wdata = 32'h0000_1000 + 32'(i);
      step();
    end
    bus.imem_we = 1'b0;

    // Reset / idle
    step();
    step();
    check("rst.pc", 32'(bus.PC), 32'h0);
    check("rst.valid", 32'(bus.valid), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle.pc", 32'(bus.PC), 32'h0);
      check("idle.valid", 32'(bus.valid), 32'h0);
    end

    // Sequential fetch: PC = 0 right after start, then +1 per cycle
    do_start();
    chk_run("seq0", 8'h00, 32'h0000_1000, 1'b1);
    for (int i = 1; i < 10; i++) begin
      step();
      chk_run("seq", 8'(i), 32'h0000_1000 + 32'(i), 1'b1);
    end

    // Stall and branch priority
    do_reset();
    do_start();
    step(); step(); step();
    chk_run("pre_stall", 8'h03, 32'h0000_1003, 1'b1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_run("stall", 8'h03, 32'h0000_1003, 1'b1);
    end
    do_branch(8'h40, 1'b1);
    chk_run("br_over_stall", 8'h40, 32'h0000_1040, 1'b1);

    // Wrap-around
    do_branch(8'hFE, 1'b0);
    chk_run("wrap_fe", 8'hFE, 32'h0000_10FE, 1'b1);
    step();
    chk_run("wrap_ff", 8'hFF, 32'h0000_10FF, 1'b1);
    step();
    chk_run("wrap_00", 8'h00, 32'h0000_1000, 1'b1);
    step();
    chk_run("wrap_01", 8'h01, 32'h0000_1001, 1'b1);

    // Reset mid-operation while stalled at 0x22
    do_branch(8'h22, 1'b1);
    bus.stall = 1'b1;
    step();
    chk_run("at22", 8'h22, 32'h0000_1022, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    bus.stall = 1'b0;
    check("midrst.pc", 32'(bus.PC), 32'h0);
    check("midrst.valid", 32'(bus.valid), 32'h0);
    step();
    check("midrst.idle_pc", 32'(bus.PC), 32'h0);
    check("midrst.idle_valid", 32'(bus.valid), 32'h0);
    do_start();
    do_branch(8'h22, 1'b0);
    chk_run("mem_kept", 8'h22, 32'h0000_1022, 1'b1);

    // Halt at PC 5
    do_reset();
    bus.imem_we    = 1'b1;
    bus.imem_waddr = 8'h05;
    bus.imem_wdata = 32'hF000_0000;
    step();
    bus.imem_we = 1'b0;
    do_start();
    for (int i = 1; i <= 5; i++) step();
    chk_run("halt_at5", 8'h05, 32'hF000_0000, 1'b1);
    step();
    chk_run("halted", 8'h05, 32'hF000_0000, 1'b0);
    bus.start = 1'b1;
    do_branch(8'h10, 1'b0);
    bus.start = 1'b0;
    chk_run("halt_ignores", 8'h05, 32'hF000_0000, 1'b0);

    // Branch overrides in-flight halt opcode
    do_reset();
    do_start();
    for (int i = 1; i <= 5; i++) step();
    chk_run("halt2_at5", 8'h05, 32'hF000_0000, 1'b1);
    do_branch(8'h10, 1'b0);
    chk_run("halt_squash", 8'h10, 32'h0000_1010, 1'b1);
    step();
    chk_run("after_squash", 8'h11, 32'h0000_1011, 1'b1);

    // Write to the address the PC moves to on the same edge
    bus.imem_we    = 1'b1;
    bus.imem_waddr = 8'h12;
    bus.imem_wdata = 32'hABCD_0012;
    step();
    bus.imem_we = 1'b0;
    chk_run("wr_same_edge", 8'h12, 32'hABCD_0012, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
